// File: rtl/load_queue_mp.sv
// Multi-ported load queue: multi-lane dispatch, multi-port address writes, oldest-ready issue
// to the D-cache and multi-entry retire. LDQ_SPEC_ISSUE_EN lets loads bypass older stores.
module load_queue_mp #(
  parameter int unsigned ENTRIES      = 16,
  parameter int unsigned SDQ_ENTRIES  = 16,
  parameter int unsigned DISP_WIDTH   = 2,
  parameter int unsigned EXEC_PORTS   = 2,
  parameter int unsigned RETIRE_WIDTH = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic [DISP_WIDTH-1:0]                         disp_vld,
  input  logic [DISP_WIDTH*($clog2(SDQ_ENTRIES)+1)-1:0] disp_sdq_marker,
  output logic [DISP_WIDTH*$clog2(ENTRIES)-1:0]         disp_ldq_idx,
  output logic                                          disp_full,
  input  logic [EXEC_PORTS-1:0]                         exec_vld,
  input  logic [EXEC_PORTS*$clog2(ENTRIES)-1:0]         exec_ldq_idx,
  input  logic [EXEC_PORTS*32-1:0]                      exec_addr,
  input  logic [$clog2(SDQ_ENTRIES):0]                  sdq_head_ptr,
  output logic                                          issue_vld,
  input  logic                                          issue_rdy,
  output logic [$clog2(ENTRIES)-1:0]                    issue_ldq_idx,
  output logic [31:0]                                   issue_addr,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0]             ret_cnt,
  output logic [$clog2(ENTRIES):0]                      count
);
  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned MW = $clog2(SDQ_ENTRIES) + 1;
  localparam int unsigned RW = $clog2(RETIRE_WIDTH + 1);

  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [ENTRIES-1:0] valid_q, valid_d, addr_vld_q, addr_vld_d;
  logic [ENTRIES-1:0] issued_q, issued_d, st_clr_q, st_clr_d;
  logic [31:0]        addr_q   [ENTRIES];
  logic [31:0]        addr_d   [ENTRIES];
  logic [MW-1:0]      marker_q [ENTRIES];
  logic [MW-1:0]      marker_d [ENTRIES];

  logic [PW-1:0]      disp_cnt;
  logic [ENTRIES-1:0] elig;
  logic               found;
  logic [IW-1:0]      sel, scan, ex_idx, al_idx;
  logic [MW-1:0]      diff;
  logic [RW-1:0]      ret_eff;

  // Lane i gets tail plus the number of valid lanes below it.
  always_comb begin
    disp_cnt = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      disp_ldq_idx[i*IW +: IW] = tail_q[IW-1:0] + disp_cnt[IW-1:0];
      disp_cnt = disp_cnt + PW'(disp_vld[i]);
    end
  end

  assign count     = tail_q - head_q;
  assign disp_full = count > PW'(ENTRIES - DISP_WIDTH);

`ifdef LDQ_SPEC_ISSUE_EN
  assign elig = valid_q & addr_vld_q & ~issued_q;
`else
  assign elig = valid_q & addr_vld_q & ~issued_q & st_clr_q;
`endif

  // Scan from head so the first hit is the oldest eligible load.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    scan  = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      scan = head_q[IW-1:0] + IW'(k);
      if (!found && elig[scan]) begin
        found = 1'b1;
        sel   = scan;
      end
    end
  end

  assign issue_vld     = found & ~flush;
  assign issue_ldq_idx = sel;
  assign issue_addr    = found ? addr_q[sel] : '0;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    addr_vld_d = addr_vld_q;
    issued_d   = issued_q;
    st_clr_d   = st_clr_q;
    addr_d     = addr_q;
    marker_d   = marker_q;
    ex_idx     = '0;
    al_idx     = '0;
    diff       = '0;

    // A wrap-aware distance of exactly SDQ_ENTRIES means the SDQ was full at dispatch.
    for (int e = 0; e < ENTRIES; e++) begin
      diff = sdq_head_ptr - marker_q[e];
      if (valid_q[e] && (diff < MW'(SDQ_ENTRIES))) st_clr_d[e] = 1'b1;
    end

    if (issue_vld && issue_rdy) issued_d[sel] = 1'b1;

    for (int p = 0; p < EXEC_PORTS; p++) begin
      ex_idx = exec_ldq_idx[p*IW +: IW];
      if (exec_vld[p] && valid_q[ex_idx]) begin
        addr_d[ex_idx]     = exec_addr[p*32 +: 32];
        addr_vld_d[ex_idx] = 1'b1;
      end
    end

    ret_eff = (ret_cnt > RW'(RETIRE_WIDTH)) ? RW'(RETIRE_WIDTH) : ret_cnt;
    for (int r = 0; r < RETIRE_WIDTH; r++) begin
      if (RW'(r) < ret_eff) valid_d[head_q[IW-1:0] + IW'(r)] = 1'b0;
    end
    head_d = head_q + PW'(ret_eff);

    // Applied after exec so allocation wins a same-cycle collision.
    if (!disp_full) begin
      for (int i = 0; i < DISP_WIDTH; i++) begin
        if (disp_vld[i]) begin
          al_idx             = disp_ldq_idx[i*IW +: IW];
          valid_d[al_idx]    = 1'b1;
          marker_d[al_idx]   = disp_sdq_marker[i*MW +: MW];
          addr_vld_d[al_idx] = 1'b0;
          issued_d[al_idx]   = 1'b0;
          st_clr_d[al_idx]   = 1'b0;
        end
      end
      tail_d = tail_q + disp_cnt;
    end

    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      addr_vld_q <= '0;
      issued_q   <= '0;
      st_clr_q   <= '0;
      addr_q     <= '{default: '0};
      marker_q   <= '{default: '0};
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      addr_vld_q <= addr_vld_d;
      issued_q   <= issued_d;
      st_clr_q   <= st_clr_d;
      addr_q     <= addr_d;
      marker_q   <= marker_d;
    end
  end

endmodule

// File: tb/tb_load_queue_mp.sv
// Self-checking bench for load_queue_mp: scenario tasks plus an issue scoreboard.
module tb_load_queue_mp;
  logic        clk = 1'b0;
  logic        rst, flush, issue_vld, issue_rdy, disp_full;
  logic [1:0]  disp_vld, exec_vld, ret_cnt;
  logic [9:0]  disp_sdq_marker;
  logic [7:0]  disp_ldq_idx, exec_ldq_idx;
  logic [63:0] exec_addr;
  logic [4:0]  sdq_head_ptr, count;
  logic [3:0]  issue_ldq_idx;
  logic [31:0] issue_addr;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;

`ifdef LDQ_SPEC_ISSUE_EN
  localparam logic [3:0]  HOLD_IDX  = 4'd0;
  localparam logic [31:0] HOLD_ADDR = 32'hA0;
`else
  localparam logic [3:0]  HOLD_IDX  = 4'd2;
  localparam logic [31:0] HOLD_ADDR = 32'hC0;
`endif

  load_queue_mp dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_vld(disp_vld), .disp_sdq_marker(disp_sdq_marker),
    .disp_ldq_idx(disp_ldq_idx), .disp_full(disp_full),
    .exec_vld(exec_vld), .exec_ldq_idx(exec_ldq_idx), .exec_addr(exec_addr),
    .sdq_head_ptr(sdq_head_ptr),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy),
    .issue_ldq_idx(issue_ldq_idx), .issue_addr(issue_addr),
    .ret_cnt(ret_cnt), .count(count)
  );

  always #5 clk = ~clk;

  // Every accepted issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && issue_vld && issue_rdy) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got idx %0d addr %h, required no issue",
                 issue_ldq_idx, issue_addr);
      end else begin
        got = sb_q.pop_front();
        if (issue_ldq_idx !== got.idx || issue_addr !== got.addr) begin
          errors++;
          $display("FAIL issue_order: got idx %0d addr %h, required idx %0d addr %h",
                   issue_ldq_idx, issue_addr, got.idx, got.addr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush    = 1'b0;
    disp_vld = '0;
    exec_vld = '0;
    ret_cnt  = '0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic disp(input logic [1:0] vld, input logic [4:0] m0, input logic [4:0] m1);
    disp_vld        = vld;
    disp_sdq_marker = {m1, m0};
  endtask

  task automatic exec_wr(input int p, input logic [3:0] idx, input logic [31:0] addr);
    exec_vld[p]            = 1'b1;
    exec_ldq_idx[p*4 +: 4] = idx;
    exec_addr[p*32 +: 32]  = addr;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_rdy = 1'b0; sdq_head_ptr = '0;
    disp_sdq_marker = '0; exec_ldq_idx = '0; exec_addr = '0;
    idle();
    repeat (2) step();
    rst = 1'b0;
    step();
    checks += 5;
    if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
    if (disp_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", disp_full); end
    if (issue_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b required 0", issue_vld); end
    if (issue_ldq_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d required 0", issue_ldq_idx); end
    if (issue_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", issue_addr); end
  endtask

  task automatic test_store_order();
    issue_rdy = 1'b1; sdq_head_ptr = 5'd3;
    disp(2'b11, 5'd5, 5'd5);
    #1;
    checks++;
    if (disp_ldq_idx !== {4'd1, 4'd0}) begin
      errors++; $display("FAIL order_disp_idx: got %h required 10", disp_ldq_idx);
    end
    step(); idle();
    checks++;
    if (count !== 5'd2) begin errors++; $display("FAIL order_count: got %0d required 2", count); end
`ifdef LDQ_SPEC_ISSUE_EN
    sb_q.push_back('{idx: 4'd0, addr: 32'h13F4});
    sb_q.push_back('{idx: 4'd1, addr: 32'h2000});
`endif
    exec_wr(0, 4'd0, 32'h13F4); exec_wr(1, 4'd1, 32'h2000);
    step(); idle();
`ifndef LDQ_SPEC_ISSUE_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (issue_vld !== 1'b0) begin errors++; $display("FAIL order_blocked: got %b required 0", issue_vld); end
      step();
    end
    sb_q.push_back('{idx: 4'd0, addr: 32'h13F4});
    sb_q.push_back('{idx: 4'd1, addr: 32'h2000});
    sdq_head_ptr = 5'd5;
    step();
    checks++;
    if (issue_vld !== 1'b1 || issue_ldq_idx !== 4'd0 || issue_addr !== 32'h13F4) begin
      errors++;
      $display("FAIL order_first: got vld %b idx %0d addr %h required 1 0 13f4",
               issue_vld, issue_ldq_idx, issue_addr);
    end
`endif
    wait_drain(10);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL order_drain: got %0d left required 0", sb_q.size()); end
    ret_cnt = 2'd2;
    step(); idle();
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL order_retire: got %0d required 0", count); end
  endtask

  task automatic test_out_of_order();
    do_flush();
    issue_rdy = 1'b1; sdq_head_ptr = 5'd5;
    disp(2'b11, 5'd5, 5'd5);
    step(); idle();
    exec_wr(1, 4'd1, 32'h100);
    sb_q.push_back('{idx: 4'd1, addr: 32'h100});
    step(); idle();
    checks++;
    if (issue_vld !== 1'b1 || issue_ldq_idx !== 4'd1) begin
      errors++; $display("FAIL ooo_first: got vld %b idx %0d required 1 1", issue_vld, issue_ldq_idx);
    end
    exec_wr(0, 4'd0, 32'h200);
    sb_q.push_back('{idx: 4'd0, addr: 32'h200});
    step(); idle();
    wait_drain(10);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL ooo_drain: got %0d left required 0", sb_q.size()); end
  endtask

  task automatic test_hold();
    do_flush();
    issue_rdy = 1'b0; sdq_head_ptr = 5'd5;
    disp(2'b11, 5'd7, 5'd5);
    step();
    disp(2'b01, 5'd5, 5'd0);
    step(); idle();
    exec_wr(0, 4'd0, 32'hA0); exec_wr(1, 4'd2, 32'hC0);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (issue_vld !== 1'b1 || issue_ldq_idx !== HOLD_IDX || issue_addr !== HOLD_ADDR) begin
        errors++;
        $display("FAIL hold_offer: got vld %b idx %0d addr %h required 1 %0d %h",
                 issue_vld, issue_ldq_idx, issue_addr, HOLD_IDX, HOLD_ADDR);
      end
      step();
    end
    sdq_head_ptr = 5'd7;
    step();
    checks++;
    if (issue_vld !== 1'b1 || issue_ldq_idx !== 4'd0 || issue_addr !== 32'hA0) begin
      errors++;
      $display("FAIL hold_switch: got vld %b idx %0d addr %h required 1 0 a0",
               issue_vld, issue_ldq_idx, issue_addr);
    end
    sb_q.push_back('{idx: 4'd0, addr: 32'hA0});
    sb_q.push_back('{idx: 4'd2, addr: 32'hC0});
    issue_rdy = 1'b1;
    wait_drain(10);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL hold_drain: got %0d left required 0", sb_q.size()); end
  endtask

  task automatic test_full();
    do_flush();
    issue_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      disp(2'b11, 5'd5, 5'd5);
      step();
    end
    idle();
    checks += 2;
    if (count !== 5'd14) begin errors++; $display("FAIL full_cnt14: got %0d required 14", count); end
    if (disp_full !== 1'b0) begin errors++; $display("FAIL full_at14: got %b required 0", disp_full); end
    disp(2'b11, 5'd5, 5'd5);
    step();
    checks += 2;
    if (count !== 5'd16) begin errors++; $display("FAIL full_cnt16: got %0d required 16", count); end
    if (disp_full !== 1'b1) begin errors++; $display("FAIL full_at16: got %b required 1", disp_full); end
    step(); idle();
    checks++;
    if (count !== 5'd16) begin errors++; $display("FAIL full_drop: got %0d required 16", count); end
    ret_cnt = 2'd1;
    step(); idle();
    checks += 2;
    if (count !== 5'd15) begin errors++; $display("FAIL full_cnt15: got %0d required 15", count); end
    if (disp_full !== 1'b1) begin errors++; $display("FAIL full_at15: got %b required 1", disp_full); end
    ret_cnt = 2'd1;
    step(); idle();
    checks++;
    if (disp_full !== 1'b0) begin errors++; $display("FAIL full_at14b: got %b required 0", disp_full); end
    disp(2'b11, 5'd5, 5'd5);
    #1;
    checks++;
    if (disp_ldq_idx !== {4'd1, 4'd0}) begin
      errors++; $display("FAIL full_wrap_idx: got %h required 10", disp_ldq_idx);
    end
    step(); idle();
    ret_cnt = 2'd3;
    step(); idle();
    checks++;
    if (count !== 5'd14) begin errors++; $display("FAIL full_ret_clamp: got %0d required 14", count); end
  endtask

  task automatic test_collision_flush();
    do_flush();
    issue_rdy = 1'b0; sdq_head_ptr = 5'd5;
    disp(2'b10, 5'd0, 5'd5);
    #1;
    checks++;
    if (disp_ldq_idx[7:4] !== 4'd0) begin
      errors++; $display("FAIL sparse_idx: got %0d required 0", disp_ldq_idx[7:4]);
    end
    step();
    disp(2'b11, 5'd5, 5'd5);
    #1;
    checks++;
    if (disp_ldq_idx !== {4'd2, 4'd1}) begin
      errors++; $display("FAIL sparse_next: got %h required 21", disp_ldq_idx);
    end
    step();
    disp(2'b01, 5'd5, 5'd0);
    step(); idle();
    exec_wr(0, 4'd3, 32'hA); exec_wr(1, 4'd3, 32'hB);
    step(); idle();
    checks++;
    if (issue_vld !== 1'b1 || issue_ldq_idx !== 4'd3 || issue_addr !== 32'hB) begin
      errors++;
      $display("FAIL collide_addr: got vld %b idx %0d addr %h required 1 3 b",
               issue_vld, issue_ldq_idx, issue_addr);
    end
    sb_q.push_back('{idx: 4'd3, addr: 32'hB});
    issue_rdy = 1'b1;
    wait_drain(10);
    issue_rdy = 1'b0;
    exec_wr(0, 4'd0, 32'h55);
    step(); idle();
    flush = 1'b1; issue_rdy = 1'b1; ret_cnt = 2'd1;
    disp(2'b11, 5'd5, 5'd5);
    exec_wr(1, 4'd1, 32'h66);
    #1;
    checks++;
    if (issue_vld !== 1'b0) begin errors++; $display("FAIL flush_vld_now: got %b required 0", issue_vld); end
    step(); idle();
    checks += 2;
    if (count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d required 0", count); end
    if (issue_vld !== 1'b0) begin errors++; $display("FAIL flush_vld_next: got %b required 0", issue_vld); end
    issue_rdy = 1'b0;
  endtask

  task automatic test_marker_boundary();
    do_flush();
    issue_rdy = 1'b1; sdq_head_ptr = 5'd0;
    disp(2'b01, 5'd16, 5'd0);
    step(); idle();
`ifdef LDQ_SPEC_ISSUE_EN
    sb_q.push_back('{idx: 4'd0, addr: 32'h77});
`endif
    exec_wr(0, 4'd0, 32'h77);
    step(); idle();
`ifdef LDQ_SPEC_ISSUE_EN
    checks++;
    if (issue_vld !== 1'b1 || issue_ldq_idx !== 4'd0) begin
      errors++; $display("FAIL spec_issue: got vld %b idx %0d required 1 0", issue_vld, issue_ldq_idx);
    end
`else
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (issue_vld !== 1'b0) begin errors++; $display("FAIL marker_full_sdq: got %b required 0", issue_vld); end
      step();
    end
    sb_q.push_back('{idx: 4'd0, addr: 32'h77});
    sdq_head_ptr = 5'd16;
`endif
    wait_drain(10);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL marker_drain: got %0d left required 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_flush();
    issue_rdy = 1'b0;
    disp(2'b11, 5'd5, 5'd5);
    step(); idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL reset_mid: got %0d required 0", count); end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_store_order();
    test_out_of_order();
    test_hold();
    test_full();
    test_collision_flush();
    test_marker_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_queue_mp.md
# load_queue_mp

Multi-ported, parametrised load queue for the LSU. Replaces the single-lane load data queue. Each cycle it takes up to DISP_WIDTH loads from dispatch and up to EXEC_PORTS address writes from the AGUs. It issues the oldest ready load to the D-cache over a valid/ready handshake and frees up to RETIRE_WIDTH entries from the head. A load is ready once its address is known and every store older than it has drained from the store data queue.

## Interface
- ENTRIES, 16, queue depth; power of two, ≥4
- SDQ_ENTRIES, 16, store data queue depth; power of two
- DISP_WIDTH, 2, dispatch lanes
- EXEC_PORTS, 2, address-write ports
- RETIRE_WIDTH, 2, maximum frees per cycle
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all entries
- disp_vld  in  DISP_WIDTH  per-lane allocate request
- disp_sdq_marker  in  DISP_WIDTH×($clog2(SDQ_ENTRIES)+1)  SDQ tail pointer (with wrap bit) at dispatch, per lane
- disp_ldq_idx  out  DISP_WIDTH×$clog2(ENTRIES)  index assigned to each lane
- disp_full  out  1  fewer than DISP_WIDTH free entries
- exec_vld  in  EXEC_PORTS  address-write valid
- exec_ldq_idx  in  EXEC_PORTS×$clog2(ENTRIES)  target entry
- exec_addr  in  EXEC_PORTS×32  load address
- sdq_head_ptr  in  $clog2(SDQ_ENTRIES)+1  SDQ drain pointer (with wrap bit)
- issue_vld  out  1  a load is offered
- issue_rdy  in  1  D-cache accepts
- issue_ldq_idx  out  $clog2(ENTRIES)  offered entry
- issue_addr  out  32  offered address
- ret_cnt  in  $clog2(RETIRE_WIDTH+1)  entries to free from head
- count  out  $clog2(ENTRIES)+1  occupied entries

## Operation
- State:
  - head and tail pointers, $clog2(ENTRIES)+1 bits each (wrap bit)
  - per entry: valid, addr_vld, issued, st_clr, addr[31:0], marker
- Dispatch:
  - Lane i takes index tail + popcount(disp_vld[i-1:0]); the disp_vld mask may be sparse.
  - tail advances by popcount(disp_vld).
  - Allocation sets valid and marker, and clears addr_vld, issued and st_clr.
  - disp_ldq_idx is combinational from tail and is driven even when the lane is invalid.
  - If disp_full=1, the whole group is dropped: no state change.
- Exec:
  - Writes addr and sets addr_vld on a valid entry.
  - A write to an invalid entry is ignored.
  - If two ports target the same index, the higher-numbered port wins.
  - If an entry is allocated and exec-written in the same cycle, allocation wins.
- Store ordering:
  - st_clr is set, and stays set, when sdq_head_ptr == marker, or when (sdq_head_ptr − marker) mod 2·SDQ_ENTRIES < SDQ_ENTRIES.
  - A difference of exactly SDQ_ENTRIES is the full-SDQ-at-dispatch case and does not set st_clr.
- Issue:
  - Eligible = valid ∧ addr_vld ∧ ¬issued ∧ st_clr.
  - The oldest eligible entry, counting from head, is offered.
  - Outputs are combinational from state.
  - On issue_vld ∧ issue_rdy, that entry's issued bit is set.
- Retire:
  - head advances by ret_cnt and the freed entries clear valid.
  - The environment guarantees ret_cnt ≤ count and that freed entries are issued. If that is violated, the entries are freed anyway.
  - ret_cnt > RETIRE_WIDTH is clamped to RETIRE_WIDTH.
- count = tail − head (wrap-aware). Full when count == ENTRIES; empty when head == tail.
- Flush:
  - Clears all valid bits and sets head = tail = 0.
  - Overrides same-cycle dispatch, exec and retire. No issue fires in a flush cycle, since issue_vld is forced to 0.

## Timing
- Reset: all entries invalid, head = tail = 0, count = 0, disp_full = 0, issue_vld = 0, issue_ldq_idx = 0, issue_addr = 0.
- Reset asserted mid-operation discards all state immediately.
- Dispatch at edge N → earliest exec write at edge N+1.
- Exec write at edge N → issue_vld in cycle N+1, if st_clr is already set.
- A sdq_head_ptr match in cycle N sets st_clr at edge N+1 → issue in cycle N+1.
- Handshake: while issue_rdy=0, the offered entry holds unless an older entry becomes eligible. The offer always tracks the oldest eligible entry.
- disp_full and count use the pre-edge occupancy; same-cycle retires do not free dispatch slots.
- Simultaneous dispatch, retire and issue in one cycle are all legal.

## Configuration
- LDQ_SPEC_ISSUE_EN defined:
  - st_clr is ignored; eligibility is valid ∧ addr_vld ∧ ¬issued.
  - Loads issue speculatively ahead of older stores.
  - sdq_head_ptr is unused.
- LDQ_SPEC_ISSUE_EN undefined: conservative ordering as described in Operation.

## Test plan
- Reset, then dispatch lanes {1,1} with markers 5 and 5, while sdq_head_ptr = 3 → disp_ldq_idx = {0,1}, count = 2. Write the addresses via exec → no issue_vld until sdq_head_ptr = 5. Then issue idx 0 (addr 0x13F4), then idx 1.
- Exec writes entry 1 before entry 0, with markers already drained → entry 1 is issued first. After entry 0's address arrives, it is offered next.
- Hold issue_rdy = 0 for 3 cycles with entry 2 eligible, then make entry 0 eligible → issue_ldq_idx switches to 0. Raise issue_rdy → entry 0 is issued, then entry 2.
- Fill to 16 entries → disp_full = 1 from count = 15; a dispatch while full is dropped. ret_cnt = 2 → count = 14. Wrap tail past index 15; indices continue from 0.
- Both exec ports target entry 3 with 0xA and 0xB → addr = 0xB. A flush in the same cycle as a dispatch → count = 0 and issue_vld = 0 next cycle.
- Marker = 16 with sdq_head_ptr = 0 (difference exactly SDQ_ENTRIES) → no issue. With LDQ_SPEC_ISSUE_EN defined → issues one cycle after its exec write.
